// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared constants and types for the multiplexed seven-segment display
// controller: blank/idle drive levels, the scan FSM state type and the
// active-low hex glyph table.
// Segment encoding everywhere is active-low {g,f,e,d,c,b,a}.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  // All anodes released (active-low).
  localparam logic [3:0] ANODE_OFF   = 4'hF;
  // Ring value that selects the rightmost digit.
  localparam logic [3:0] ANODE_FIRST = 4'hE;
  // Ring value that selects the leftmost digit; the tick leaving it ends a frame.
  localparam logic [3:0] ANODE_LAST  = 4'h7;

  // Scan FSM: S_IDLE waits for the first dwell tick after reset.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  // Active-low glyphs, entry [n] is the pattern for hex digit n.
  // Listed from F down to 0 so the packed index matches the nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  // Table lookup for one hex nibble.
  function automatic logic [6:0] hex_segments(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// seven_seg_display_ctrl_if
// Valid/ready channel that carries a new 16-bit display value into the
// controller.
//   value        16  four hex digits, [3:0] = rightmost digit
//   value_valid   1  source presents value (must hold until accepted)
//   value_ready   1  controller can accept a value
// Modports: master = value source, slave = display controller.
// -----------------------------------------------------------------------------
interface seven_seg_display_ctrl_if;

  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;

  modport master (
    output value,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/hex_to_seven_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seven_seg
// Purely combinational hex nibble to active-low seven-segment decoder.
//   i_nibble  in   4  hex digit
//   o_seg     out  7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Glyph lookup from the shared table.
  always_comb begin
    o_seg = hex_segments(i_nibble);
  end

endmodule

// File: rtl/seven_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seven_seg_display_ctrl
// Drives a 4-digit multiplexed seven-segment display from a 16-bit hex value.
// A free-running dwell counter produces one tick every DWELL_CYCLES clocks;
// each tick advances an active-low anode ring one digit to the left.
// New values arrive over a valid/ready channel into a one-entry pending
// buffer and are copied into the shown value only at a frame boundary (the
// tick that wraps the ring from the leftmost digit back to the rightmost), so
// a frame never mixes two values.
//
// Parameters
//   DWELL_CYCLES  clocks each digit stays selected (>= 2)
// Ports
//   i_clock       in   1   system clock, rising edge
//   i_reset       in   1   asynchronous reset, active-low
//   s_value       slave    value / value_valid / value_ready channel
//   i_digit_en    in   4   per-digit enable, 1 = shown
//   i_lz_blank    in   1   1 = blank leading zeros
//   o_anode       out  4   active-low digit select, [0] = right digit
//   o_seg         out  7   active-low segments {g,f,e,d,c,b,a}
//   o_frame_done  out  1   one-cycle pulse after each frame boundary tick
//   i_dp_mask     in   4   (DECIMAL_POINT_EN only) 1 = decimal point on
//   o_dp          out  1   (DECIMAL_POINT_EN only) active-low decimal point
//
// Build option: define DECIMAL_POINT_EN to add the decimal point port pair.
// -----------------------------------------------------------------------------
module seven_seg_display_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DWELL_CYCLES = 100000
)
(
  input  logic                     i_clock,
  input  logic                     i_reset,
  seven_seg_display_ctrl_if.slave  s_value,
  input  logic [3:0]               i_digit_en,
  input  logic                     i_lz_blank,
  output logic [3:0]               o_anode,
  output logic [6:0]               o_seg,
  output logic                     o_frame_done
`ifdef DECIMAL_POINT_EN
  ,
  input  logic [3:0]               i_dp_mask,
  output logic                     o_dp
`endif
);

  localparam int             CW       = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL_CYCLES - 1);

  // Registered state.
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [3:0]    r_ring;
  logic [3:0]    r_anode;
  logic [6:0]    r_seg;
  logic          r_frame_done;
  logic [15:0]   r_pending;
  logic          r_pending_full;
  logic [15:0]   r_shown;
  logic          r_value_ready;

  // Combinational next-state and datapath nets.
  logic          w_tick;
  state_t        w_state_nxt;
  logic [3:0]    w_ring_nxt;
  logic          w_boundary;
  logic          w_transfer;
  logic          w_capture;
  logic [1:0]    w_sel;
  logic [15:0]   w_src;
  logic [3:0]    w_nibble;
  logic          w_lz_zero;
  logic          w_blank;
  logic [6:0]    w_dec_seg;

  assign w_tick     = (r_count == CNT_LAST);
  assign w_transfer = w_boundary & r_pending_full;
  assign w_capture  = s_value.value_valid & r_value_ready;

  // Scan FSM next state and ring rotation; flags the frame boundary tick.
  always_comb begin
    w_state_nxt = r_state;
    w_ring_nxt  = r_ring;
    w_boundary  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_SCAN;
          w_ring_nxt  = ANODE_FIRST;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (w_tick) begin
          w_ring_nxt = {r_ring[2:0], r_ring[3]};
          w_boundary = (r_ring == ANODE_LAST);
        end else begin
          w_ring_nxt = r_ring;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ring_nxt  = ANODE_OFF;
      end
    endcase
  end

  // Digit index of the slot being entered at the next tick.
  always_comb begin
    case (w_ring_nxt)
      4'b1110: w_sel = 2'd0;
      4'b1101: w_sel = 2'd1;
      4'b1011: w_sel = 2'd2;
      4'b0111: w_sel = 2'd3;
      default: w_sel = 2'd0;
    endcase
  end

  // On a boundary that transfers a new value, the new frame must already use
  // it for digit 0, so the decode source bypasses the shown register then.
  always_comb begin
    w_src    = w_transfer ? r_pending : r_shown;
    w_nibble = w_src[{w_sel, 2'b00} +: 4];
  end

  // Leading-zero test: this digit and every digit to its left are zero.
  // Digit 0 is never treated as a leading zero so 0000 still shows "0".
  always_comb begin
    case (w_sel)
      2'd0:    w_lz_zero = 1'b0;
      2'd1:    w_lz_zero = (w_src[15:4]  == 12'h000);
      2'd2:    w_lz_zero = (w_src[15:8]  == 8'h00);
      2'd3:    w_lz_zero = (w_src[15:12] == 4'h0);
      default: w_lz_zero = 1'b0;
    endcase
    w_blank = ~i_digit_en[w_sel] | (i_lz_blank & w_lz_zero);
  end

  hex_to_seven_seg u_hex_to_seven_seg (
    .i_nibble (w_nibble),
    .o_seg    (w_dec_seg)
  );

  // Dwell counter: free-running 0..DWELL_CYCLES-1.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= CNT_ZERO;
    end else if (w_tick) begin
      r_count <= CNT_ZERO;
    end else begin
      r_count <= r_count + CNT_ONE;
    end
  end

  // FSM state and anode ring registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_ring  <= ANODE_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_ring  <= w_ring_nxt;
    end
  end

  // Display outputs: anode and segments change together only on a tick, a
  // blanked slot keeps its anode released for the whole dwell.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_anode      <= ANODE_OFF;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_tick) begin
        r_anode <= w_blank ? ANODE_OFF : w_ring_nxt;
        r_seg   <= w_blank ? SEG_BLANK : w_dec_seg;
      end
    end
  end

  // Handshake and value buffers: one pending slot, emptied into the shown
  // value at a frame boundary. ready is low exactly while pending is full.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pending      <= 16'h0000;
      r_pending_full <= 1'b0;
      r_shown        <= 16'h0000;
      r_value_ready  <= 1'b1;
    end else if (w_transfer) begin
      r_shown        <= r_pending;
      r_pending_full <= 1'b0;
      r_value_ready  <= 1'b1;
    end else if (w_capture) begin
      r_pending      <= s_value.value;
      r_pending_full <= 1'b1;
      r_value_ready  <= 1'b0;
    end
  end

  assign o_anode             = r_anode;
  assign o_seg               = r_seg;
  assign o_frame_done        = r_frame_done;
  assign s_value.value_ready = r_value_ready;

`ifdef DECIMAL_POINT_EN
  logic r_dp;

  // Decimal point follows the same sampling and blanking as the segments.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_dp <= 1'b1;
    end else if (w_tick) begin
      r_dp <= w_blank ? 1'b1 : ~i_dp_mask[w_sel];
    end
  end

  assign o_dp = r_dp;
`endif

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_display_ctrl
// Directed bench for seven_seg_display_ctrl with DWELL_CYCLES = 4 (16-cycle
// frames). Inputs are driven and outputs sampled on the falling clock edge.
// Define DECIMAL_POINT_EN to also exercise the decimal point output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seven_seg_display_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] digit_en;
  logic       lz_blank;
  logic [3:0] anode;
  logic [6:0] seg;
  logic       frame_done;
`ifdef DECIMAL_POINT_EN
  logic [3:0] dp_mask;
  logic       dp;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seven_seg_display_ctrl_if vif ();

  seven_seg_display_ctrl #(.DWELL_CYCLES(4)) dut (
    .i_clock      (clock),
    .i_reset      (reset),
    .s_value      (vif),
    .i_digit_en   (digit_en),
    .i_lz_blank   (lz_blank),
    .o_anode      (anode),
    .o_seg        (seg),
    .o_frame_done (frame_done)
`ifdef DECIMAL_POINT_EN
    ,
    .i_dp_mask    (dp_mask),
    .o_dp         (dp)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Present a value and hold it until the controller is ready; the capture
  // edge is the rising edge after the first falling edge that sees ready.
  task automatic send(input logic [15:0] v);
    int n = 0;
    vif.value       = v;
    vif.value_valid = 1'b1;
    while (vif.value_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check_eq("send accepted", {15'd0, vif.value_ready}, 16'd1);
    step();
    vif.value_valid = 1'b0;
  endtask

  // Advance to the first cycle of the next frame.
  task automatic wait_frame_done(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    check_eq(tag, {15'd0, frame_done}, 16'd1);
  endtask

  // After reset release the first digit must appear after exactly 4 clocks.
  task automatic wait_first_digit(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (anode === 4'hF && n < 20);
    check_eq({tag, " latency"},    n[15:0], 16'd4);
    check_eq({tag, " anode"},      {12'd0, anode}, 16'h000E);
    check_eq({tag, " seg"},        {9'd0, seg}, 16'h0040);
    check_eq({tag, " frame_done"}, {15'd0, frame_done}, 16'd0);
  endtask

  // Check a whole 16-cycle frame starting at its first cycle, then the
  // frame_done pulse that opens the next frame.
  task automatic check_frame(input string tag, input logic [3:0][3:0] exp_an,
                             input logic [3:0][6:0] exp_seg);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        string t;
        t = $sformatf("%s s%0d c%0d", tag, s, c);
        check_eq({t, " anode"}, {12'd0, anode}, {12'd0, exp_an[s]});
        check_eq({t, " seg"},   {9'd0, seg},    {9'd0, exp_seg[s]});
        check_eq({t, " frame_done"}, {15'd0, frame_done},
                 {15'd0, (s == 0 && c == 0)});
`ifdef DECIMAL_POINT_EN
        check_eq({t, " dp"}, {15'd0, dp},
                 {15'd0, (exp_an[s] == 4'hF) ? 1'b1 : ~dp_mask[s]});
`endif
        step();
      end
    end
    check_eq({tag, " next boundary"}, {15'd0, frame_done}, 16'd1);
  endtask

  initial begin
    reset           = 1'b0;
    digit_en        = 4'hF;
    lz_blank        = 1'b0;
    vif.value       = 16'h0000;
    vif.value_valid = 1'b0;
`ifdef DECIMAL_POINT_EN
    dp_mask         = 4'b0010;
`endif

    // Reset state.
    repeat (3) step();
    check_eq("reset anode",      {12'd0, anode}, 16'h000F);
    check_eq("reset seg",        {9'd0, seg}, 16'h007F);
    check_eq("reset ready",      {15'd0, vif.value_ready}, 16'd1);
    check_eq("reset frame_done", {15'd0, frame_done}, 16'd0);
`ifdef DECIMAL_POINT_EN
    check_eq("reset dp",         {15'd0, dp}, 16'd1);
`endif
    reset = 1'b1;

    // 1: first tick shows cleared value, then 1234 appears from the next frame.
    wait_first_digit("t1 first");
    send(16'h1234);
    check_eq("t1 ready low", {15'd0, vif.value_ready}, 16'd0);
    wait_frame_done("t1 boundary");
    check_eq("t1 ready back", {15'd0, vif.value_ready}, 16'd1);
    check_frame("t1", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});

    // 2: AAAA pending, 5555 held mid-frame while ready stays low.
    send(16'hAAAA);
    check_eq("t2 ready low", {15'd0, vif.value_ready}, 16'd0);
    repeat (5) step();
    vif.value       = 16'h5555;
    vif.value_valid = 1'b1;
    for (int k = 6; k < 16; k++) begin
      check_eq($sformatf("t2 hold c%0d ready", k), {15'd0, vif.value_ready}, 16'd0);
      step();
    end
    check_eq("t2 b1 frame_done", {15'd0, frame_done}, 16'd1);
    check_eq("t2 b1 ready",      {15'd0, vif.value_ready}, 16'd1);
    check_eq("t2 b1 anode",      {12'd0, anode}, 16'h000E);
    check_eq("t2 b1 seg A",      {9'd0, seg}, 16'h0008);
    step();
    vif.value_valid = 1'b0;
    check_eq("t2 5555 captured", {15'd0, vif.value_ready}, 16'd0);
    wait_frame_done("t2 b2");
    check_frame("t2", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010});

    // 3: leading-zero blanking.
    lz_blank = 1'b1;
    send(16'h0050);
    wait_frame_done("t3a boundary");
    check_frame("t3a", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'b0010010, 7'b1000000});
    send(16'h0000);
    wait_frame_done("t3b boundary");
    check_frame("t3b", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'h7F, 7'h7F, 7'h7F, 7'b1000000});

    // 4: digit enables, frame period unchanged.
    digit_en = 4'b0101;
    lz_blank = 1'b0;
    send(16'h8888);
    wait_frame_done("t4 boundary");
    check_frame("t4", {4'b1111, 4'b1011, 4'b1111, 4'b1110},
                {7'h7F, 7'b0000000, 7'h7F, 7'b0000000});

    // 5: reset mid-scan with a value pending.
    digit_en = 4'hF;
    send(16'h1234);
    check_eq("t5 pending", {15'd0, vif.value_ready}, 16'd0);
    repeat (7) step();
    check_eq("t5 slot2 anode", {12'd0, anode}, 16'h000B);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5 rst anode",      {12'd0, anode}, 16'h000F);
    check_eq("t5 rst seg",        {9'd0, seg}, 16'h007F);
    check_eq("t5 rst ready",      {15'd0, vif.value_ready}, 16'd1);
    check_eq("t5 rst frame_done", {15'd0, frame_done}, 16'd0);
`ifdef DECIMAL_POINT_EN
    check_eq("t5 rst dp",         {15'd0, dp}, 16'd1);
`endif
    step();
    step();
    reset = 1'b1;
    wait_first_digit("t5 first");
    wait_frame_done("t5 boundary");
    check_frame("t5", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
